// File: rtl/word_align_ctrl.sv
// Per-lane word alignment controller: hunts for the training word across all
// eight bit offsets, confirms it, then holds the one-hot demux window select.
module word_align_ctrl #(
  parameter logic [7:0] SYNC_PATTERN = 8'hF0,
  parameter int         LOCK_COUNT   = 4,
  parameter int         TIMEOUT      = 1024,
  parameter int         TIMEOUT_W    = 10
) (
  input  logic        par_clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        resync,
  input  logic [14:0] data_ext,
  output logic [7:0]  select,
  output logic [2:0]  offset,
  output logic        locked,
  output logic        align_err
);

  localparam int MW = $clog2(LOCK_COUNT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEARCH  = 2'd1;
  localparam logic [1:0] CONFIRM = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;

  logic [1:0]           state;
  logic [MW-1:0]        match_cnt;
  logic [TIMEOUT_W-1:0] timeout_cnt;
  logic                 hit;
  logic [2:0]           hit_k;
  logic                 win_ok;

  // Ascending scan so the highest matching offset wins.
  always_comb begin
    hit   = 1'b0;
    hit_k = '0;
    for (int k = 0; k < 8; k++) begin
      if (data_ext[k +: 8] == SYNC_PATTERN) begin
        hit   = 1'b1;
        hit_k = 3'(k);
      end
    end
  end

  assign win_ok = (data_ext[offset +: 8] == SYNC_PATTERN);

  always_ff @(posedge par_clock) begin
    if (!reset_n || !enable) begin
      state       <= IDLE;
      select      <= '0;
      offset      <= '0;
      locked      <= 1'b0;
      align_err   <= 1'b0;
      match_cnt   <= '0;
      timeout_cnt <= '0;
    end else if (resync) begin
      state       <= SEARCH;
      select      <= '0;
      offset      <= '0;
      locked      <= 1'b0;
      align_err   <= 1'b0;
      match_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        IDLE: state <= SEARCH;
        SEARCH: begin
          if (hit) begin
            offset      <= hit_k;
            select      <= 8'b1 << hit_k;
            match_cnt   <= MW'(1);
            timeout_cnt <= '0;
            if (LOCK_COUNT == 1) begin
              locked <= 1'b1;
              state  <= LOCKED;
            end else begin
              state  <= CONFIRM;
            end
          end else if (timeout_cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
            align_err   <= 1'b1;
            timeout_cnt <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        CONFIRM: begin
          if (win_ok) begin
            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
              locked <= 1'b1;
              state  <= LOCKED;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end else begin
            // Drop the candidate entirely; offset only means something with select.
            select    <= '0;
            offset    <= '0;
            match_cnt <= '0;
            state     <= SEARCH;
          end
        end
        LOCKED:  state <= LOCKED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_align_ctrl.sv
// Bench for word_align_ctrl: two instances (LOCK_COUNT 4 and 1) on shared
// inputs, checked every cycle against a run-length reference model.
module tb_word_align_ctrl;

  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rs = 1'b0;
  logic [14:0] d = '0;

  logic [7:0] s4, s1;
  logic [2:0] o4, o1;
  logic       l4, l1, e4, e1;

  int ncheck = 0;
  int npass = 0;

  always #5 clk = ~clk;

  word_align_ctrl #(.LOCK_COUNT(4)) u4 (
    .par_clock(clk), .reset_n(rst_n), .enable(en), .resync(rs),
    .data_ext(d), .select(s4), .offset(o4), .locked(l4), .align_err(e4)
  );

  word_align_ctrl #(.LOCK_COUNT(1)) u1 (
    .par_clock(clk), .reset_n(rst_n), .enable(en), .resync(rs),
    .data_ext(d), .select(s1), .offset(o1), .locked(l1), .align_err(e1)
  );

  // mode: 0 idle, 1 hunting, 2 candidate held, 3 aligned
  typedef struct {
    int mode;
    int k;
    int run;
    int miss;
    bit lk;
    bit err;
  } mdl_t;

  mdl_t m[2];

  function automatic bit win_is_pat(logic [14:0] v, int k);
    logic [14:0] w;
    w = (v >> k) & 15'h00FF;
    return w == 15'h00F0;
  endfunction

  function automatic int best_k(logic [14:0] v);
    int b;
    b = -1;
    for (int k = 0; k < 8; k++) if (win_is_pat(v, k)) b = k;
    return b;
  endfunction

  function automatic mdl_t step(mdl_t x, int lc, logic r, logic e,
                                logic s, logic [14:0] v);
    mdl_t z;
    int b;
    z = '{default: 0};
    if (!r || !e) return z;
    if (s) begin
      z.mode = 1;
      return z;
    end
    b = best_k(v);
    case (x.mode)
      0: x.mode = 1;
      1: begin
        if (b >= 0) begin
          x.k = b;
          x.run = 1;
          x.miss = 0;
          if (x.run >= lc) begin x.mode = 3; x.lk = 1; end
          else x.mode = 2;
        end else begin
          x.miss++;
          if (x.miss == TMO) begin x.err = 1; x.miss = 0; end
        end
      end
      2: begin
        if (win_is_pat(v, x.k)) begin
          x.run++;
          if (x.run >= lc) begin x.mode = 3; x.lk = 1; end
        end else begin
          x.mode = 1; x.k = 0; x.run = 0;
        end
      end
      default: ;
    endcase
    return x;
  endfunction

  function automatic logic [12:0] mexp(mdl_t x);
    logic [7:0] s;
    logic [2:0] o;
    s = (x.mode >= 2) ? 8'(1 << x.k) : 8'h00;
    o = (x.mode >= 2) ? 3'(x.k) : 3'd0;
    return {s, o, x.lk, x.err};
  endfunction

  function automatic logic [14:0] pat_at(int k);
    logic [14:0] fill;
    fill = 15'($urandom) & ~(15'h00FF << k);
    return (15'h00F0 << k) | fill;
  endfunction

  function automatic logic [14:0] garbage();
    logic [14:0] v;
    v = 15'($urandom);
    for (int i = 0; i < 64 && best_k(v) >= 0; i++) v = 15'($urandom);
    if (best_k(v) >= 0) v = 15'h5555;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    m[0] = step(m[0], 4, rst_n, en, rs, d);
    m[1] = step(m[1], 1, rst_n, en, rs, d);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; rs = 1'b1; d = pat_at(3);
    tick();
    if ({s4, o4, l4, e4} !== 13'h0) begin
      $display("FAIL reset u4 got %h exp 0", {s4, o4, l4, e4});
    end else npass++;
    ncheck++;
    if ({s1, o1, l1, e1} !== 13'h0) begin
      $display("FAIL reset u1 got %h exp 0", {s1, o1, l1, e1});
    end else npass++;
    ncheck++;
  endtask

  task automatic test_lock_k3();
    rst_n = 1'b1; rs = 1'b0; en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      d = pat_at(3);
      tick();
      if ({s4, o4, l4, e4} !== mexp(m[0])) begin
        $display("FAIL lock_k3 c%0d got %h exp %h", i, {s4, o4, l4, e4}, mexp(m[0]));
      end else npass++;
      ncheck++;
      if (i == 2) begin
        if (s4 !== 8'h08 || l4 !== 1'b0) begin
          $display("FAIL lock_k3_sel got %h/%b exp 08/0", s4, l4);
        end else npass++;
        ncheck++;
      end
      if (i == 5) begin
        if (l4 !== 1'b1 || o4 !== 3'd3) begin
          $display("FAIL lock_k3_lock got %b/%0d exp 1/3", l4, o4);
        end else npass++;
        ncheck++;
      end
    end
  endtask

  task automatic test_lock1_k0();
    en = 1'b0; tick();
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d = pat_at(0);
      tick();
      if ({s1, o1, l1, e1} !== mexp(m[1])) begin
        $display("FAIL lc1 c%0d got %h exp %h", i, {s1, o1, l1, e1}, mexp(m[1]));
      end else npass++;
      ncheck++;
      if (i == 2) begin
        if (s1 !== 8'h01 || l1 !== 1'b1) begin
          $display("FAIL lc1_direct got %h/%b exp 01/1", s1, l1);
        end else npass++;
        ncheck++;
      end
    end
  endtask

  task automatic test_false_start();
    logic seen_lock;
    seen_lock = 1'b0;
    en = 1'b0; tick();
    en = 1'b1; d = garbage(); tick();
    for (int i = 1; i <= 11; i++) begin
      if (i <= 2) d = pat_at(5);
      else if (i <= 5) d = garbage();
      else d = pat_at(6);
      tick();
      if (i <= 5) seen_lock |= l4;
      if ({s4, o4, l4, e4} !== mexp(m[0])) begin
        $display("FAIL false_start c%0d got %h exp %h", i, {s4, o4, l4, e4}, mexp(m[0]));
      end else npass++;
      ncheck++;
      if (i == 3 && s4 !== 8'h00) begin
        $display("FAIL false_start_drop got %h exp 00", s4);
      end else if (i == 3) npass++;
      if (i == 3) ncheck++;
      if (i == 6 && s4 !== 8'h40) begin
        $display("FAIL false_start_k6 got %h exp 40", s4);
      end else if (i == 6) npass++;
      if (i == 6) ncheck++;
      if (i == 9 && (l4 !== 1'b1 || o4 !== 3'd6)) begin
        $display("FAIL false_start_lock got %b/%0d exp 1/6", l4, o4);
      end else if (i == 9) npass++;
      if (i == 9) ncheck++;
    end
    if (seen_lock !== 1'b0) begin
      $display("FAIL false_start_nolock got %b exp 0", seen_lock);
    end else npass++;
    ncheck++;
  endtask

  task automatic test_timeout();
    en = 1'b0; tick();
    en = 1'b1; d = '0; tick();
    for (int i = 1; i <= TMO + 3; i++) begin
      tick();
      if ({s4, o4, l4, e4} !== mexp(m[0]) || {s1, o1, l1, e1} !== mexp(m[1])) begin
        $display("FAIL timeout c%0d got %h/%h exp %h/%h", i, {s4, o4, l4, e4},
                 {s1, o1, l1, e1}, mexp(m[0]), mexp(m[1]));
      end else npass++;
      ncheck++;
      if (i == TMO - 1 && e4 !== 1'b0) begin
        $display("FAIL timeout_early got %b exp 0", e4);
      end else if (i == TMO - 1) npass++;
      if (i == TMO - 1) ncheck++;
      if (i == TMO && e4 !== 1'b1) begin
        $display("FAIL timeout_set got %b exp 1", e4);
      end else if (i == TMO) npass++;
      if (i == TMO) ncheck++;
    end
    for (int i = 1; i <= 5; i++) begin
      d = pat_at(2);
      tick();
      if ({s4, o4, l4, e4} !== mexp(m[0])) begin
        $display("FAIL timeout_relock c%0d got %h exp %h", i, {s4, o4, l4, e4}, mexp(m[0]));
      end else npass++;
      ncheck++;
    end
    if (l4 !== 1'b1 || e4 !== 1'b1 || o4 !== 3'd2) begin
      $display("FAIL timeout_sticky got %b/%b/%0d exp 1/1/2", l4, e4, o4);
    end else npass++;
    ncheck++;
  endtask

  task automatic test_resync();
    en = 1'b0; tick();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin d = pat_at(7); tick(); end
    if (l4 !== 1'b1 || s4 !== 8'h80) begin
      $display("FAIL resync_pre got %b/%h exp 1/80", l4, s4);
    end else npass++;
    ncheck++;
    rs = 1'b1; d = pat_at(1); tick();
    rs = 1'b0;
    if ({s4, l4, e4} !== 10'h0 || {s4, o4, l4, e4} !== mexp(m[0])) begin
      $display("FAIL resync_drop got %h exp %h", {s4, o4, l4, e4}, mexp(m[0]));
    end else npass++;
    ncheck++;
    for (int i = 1; i <= 5; i++) begin
      d = pat_at(1);
      tick();
      if ({s4, o4, l4, e4} !== mexp(m[0]) || {s1, o1, l1, e1} !== mexp(m[1])) begin
        $display("FAIL resync_relock c%0d got %h/%h exp %h/%h", i, {s4, o4, l4, e4},
                 {s1, o1, l1, e1}, mexp(m[0]), mexp(m[1]));
      end else npass++;
      ncheck++;
    end
    if (l4 !== 1'b1 || o4 !== 3'd1) begin
      $display("FAIL resync_final got %b/%0d exp 1/1", l4, o4);
    end else npass++;
    ncheck++;
  endtask

  task automatic test_abort();
    en = 1'b0; tick();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin d = pat_at(4); tick(); end
    en = 1'b0; tick();
    if ({s4, o4, l4, e4} !== 13'h0 || {s4, o4, l4, e4} !== mexp(m[0])) begin
      $display("FAIL abort_enable got %h exp 0", {s4, o4, l4, e4});
    end else npass++;
    ncheck++;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin d = pat_at(4); tick(); end
    rst_n = 1'b0; rs = 1'b1; tick();
    if ({s4, o4, l4, e4} !== 13'h0 || {s1, o1, l1, e1} !== 13'h0) begin
      $display("FAIL abort_reset got %h/%h exp 0", {s4, o4, l4, e4}, {s1, o1, l1, e1});
    end else npass++;
    ncheck++;
    rst_n = 1'b1; rs = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      d = pat_at(4);
      tick();
      if ({s4, o4, l4, e4} !== mexp(m[0]) || {s1, o1, l1, e1} !== mexp(m[1])) begin
        $display("FAIL abort_after c%0d got %h/%h exp %h/%h", i, {s4, o4, l4, e4},
                 {s1, o1, l1, e1}, mexp(m[0]), mexp(m[1]));
      end else npass++;
      ncheck++;
    end
  endtask

  initial begin
    m[0] = '{default: 0};
    m[1] = '{default: 0};
    test_reset();
    test_lock_k3();
    test_lock1_k0();
    test_false_start();
    test_timeout();
    test_resync();
    test_abort();
    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
